// File: rtl/bk_mem_pkg.sv
// Shared definitions for the BK memory subsystem: SRAM arbiter state
// encoding, the default video window base and CPU address helpers.
package bk_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CPU_ACC  = 2'd1,
    ST_HOST_ACC = 2'd2,
    ST_WAIT_END = 2'd3
  } arb_state_t;

  // Upper SRAM address bits that place the 8K-word video buffer.
  localparam logic [4:0] VIDEO_BASE_DEF = 5'b00001;

  // The CPU issues byte addresses; the SRAM is word addressed.
  function automatic logic [14:0] cpu_word(input logic [15:0] adr);
    return adr[15:1];
  endfunction

endpackage

// File: rtl/req_edge_det.sv
// Rising-edge detector for the CPU read/write strobes. One pulse per new
// request; a strobe held high across reset does not count as an edge.
module req_edge_det (
  input  logic clk25,
  input  logic reset_n,
  input  logic cpu_rd,
  input  logic cpu_wt,
  output logic rise
);

  logic rd_q;
  logic wt_q;

  // Previous-cycle copies of the strobes, reset high so only a fresh rise arms a request.
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      rd_q <= 1'b1;
      wt_q <= 1'b1;
    end else begin
      rd_q <= cpu_rd;
      wt_q <= cpu_wt;
    end
  end

  assign rise = (cpu_rd & ~rd_q) | (cpu_wt & ~wt_q);

endmodule

// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter: video fetch (absolute priority, one slot in 16),
// CPU access, then an optional host port.
// Build option: define HOST_PORT_EN to enable the host path; otherwise the
// host inputs are ignored, host_ack_o stays 0 and host_din_o stays 0.
//
// CPU handshake: a rising edge on cpu_rd_i or cpu_wt_i posts a request that
// is never dropped. After the one-cycle SRAM access cpu_reply_o rises and
// stays high until the CPU releases both strobes; it clears on the following
// edge. Host handshake: host_req_i is a level; each served access returns a
// single-cycle host_ack_o, and a new host access is not started in the cycle
// in which host_ack_o is high, so the host has one cycle to drop the request.
module sram_arbiter
  import bk_mem_pkg::*;
#(
  parameter int         ADDR_W     = 18,
  parameter logic [4:0] VIDEO_BASE = VIDEO_BASE_DEF
) (
  input  logic              clk25,
  input  logic              reset_n,
  input  logic              video_load_i,
  input  logic [12:0]       video_addr_i,
  output logic [15:0]       video_data_o,
  input  logic              cpu_rd_i,
  input  logic              cpu_wt_i,
  input  logic              cpu_byte_i,
  input  logic [15:0]       cpu_adr_i,
  input  logic [15:0]       cpu_dout_i,
  output logic [15:0]       cpu_din_o,
  output logic              cpu_reply_o,
  input  logic              host_req_i,
  input  logic              host_we_n_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [15:0]       host_dout_i,
  output logic              host_ack_o,
  output logic [15:0]       host_din_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  input  logic [15:0]       sram_dq_i,
  output logic [15:0]       sram_dq_o,
  output logic              sram_dq_oe_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic              sram_lb_n_o,
  output logic              sram_ub_n_o,
  output arb_state_t        dbg_state
);

`ifdef HOST_PORT_EN
  localparam bit HOST_EN = 1'b1;
`else
  localparam bit HOST_EN = 1'b0;
`endif

  arb_state_t state;
  logic       pending;
  logic       cpu_rise;
  logic       cpu_req;
  logic       video_act;
  logic       take_cpu;
  logic       take_host;

  req_edge_det u_edge (
    .clk25   (clk25),
    .reset_n (reset_n),
    .cpu_rd  (cpu_rd_i),
    .cpu_wt  (cpu_wt_i),
    .rise    (cpu_rise)
  );

  // Video slots are ignored while reset is held so the SRAM stays quiet.
  assign video_act = video_load_i & reset_n;
  assign cpu_req   = pending | cpu_rise;
  assign take_cpu  = (state == ST_IDLE) & cpu_req & ~video_act;
  assign take_host = (state == ST_IDLE) & HOST_EN & host_req_i & ~host_ack_o
                     & ~cpu_req & ~video_act;
  assign dbg_state = state;

  // Arbiter FSM; an access state that collides with a video slot waits it out.
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      pending     <= 1'b0;
      cpu_reply_o <= 1'b0;
      host_ack_o  <= 1'b0;
      cpu_din_o   <= '0;
      host_din_o  <= '0;
    end else begin
      host_ack_o <= 1'b0;
      pending    <= cpu_req & ~take_cpu;
      case (state)
        ST_IDLE: begin
          if (take_cpu)       state <= ST_CPU_ACC;
          else if (take_host) state <= ST_HOST_ACC;
        end
        ST_CPU_ACC: begin
          if (!video_act) begin
            if (!cpu_wt_i) cpu_din_o <= sram_dq_i;
            cpu_reply_o <= 1'b1;
            state       <= ST_WAIT_END;
          end
        end
        ST_HOST_ACC: begin
          if (!video_act) begin
            if (host_we_n_i) host_din_o <= sram_dq_i;
            host_ack_o <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        ST_WAIT_END: begin
          if (!cpu_rd_i && !cpu_wt_i) begin
            cpu_reply_o <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Video word capture at the end of every video slot.
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n)       video_data_o <= '0;
    else if (video_act) video_data_o <= sram_dq_i;
  end

  // SRAM pin mux: video overrides everything, otherwise the current access.
  always_comb begin
    sram_addr_o  = '0;
    sram_dq_o    = '0;
    sram_dq_oe_o = 1'b0;
    sram_oe_n_o  = 1'b1;
    sram_we_n_o  = 1'b1;
    sram_lb_n_o  = 1'b1;
    sram_ub_n_o  = 1'b1;
    if (video_act) begin
      sram_addr_o = ADDR_W'({VIDEO_BASE, video_addr_i});
      sram_oe_n_o = 1'b0;
      sram_lb_n_o = 1'b0;
      sram_ub_n_o = 1'b0;
    end else begin
      case (state)
        ST_CPU_ACC: begin
          sram_addr_o = ADDR_W'(cpu_word(cpu_adr_i));
          sram_lb_n_o = cpu_byte_i & cpu_adr_i[0];
          sram_ub_n_o = cpu_byte_i & ~cpu_adr_i[0];
          if (cpu_wt_i) begin
            sram_we_n_o  = 1'b0;
            sram_dq_oe_o = 1'b1;
            sram_dq_o    = cpu_dout_i;
          end else begin
            sram_oe_n_o = 1'b0;
          end
        end
        ST_HOST_ACC: begin
          sram_addr_o = host_addr_i;
          sram_lb_n_o = 1'b0;
          sram_ub_n_o = 1'b0;
          if (!host_we_n_i) begin
            sram_we_n_o  = 1'b0;
            sram_dq_oe_o = 1'b1;
            sram_dq_o    = host_dout_i;
          end else begin
            sram_oe_n_o = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter: SRAM device model, transaction-level reference
// memory, background video slot generator/checker and directed + random CPU
// transactions. Build with HOST_PORT_EN to exercise the host path.
module tb_sram_arbiter;
  import bk_mem_pkg::*;

  localparam int ADDR_W = 18;

  // ---------------- clock / reset ----------------
  logic clk25 = 1'b0;
  logic reset_n = 1'b1;
  always #20 clk25 = ~clk25;

  // ---------------- DUT signals ----------------
  logic              video_load_i = 1'b0;
  logic [12:0]       video_addr_i = '0;
  logic [15:0]       video_data_o;
  logic              cpu_rd_i = 1'b0, cpu_wt_i = 1'b0, cpu_byte_i = 1'b0;
  logic [15:0]       cpu_adr_i = '0, cpu_dout_i = '0;
  logic [15:0]       cpu_din_o;
  logic              cpu_reply_o;
  logic              host_req_i = 1'b0, host_we_n_i = 1'b1;
  logic [ADDR_W-1:0] host_addr_i = '0;
  logic [15:0]       host_dout_i = '0;
  logic              host_ack_o;
  logic [15:0]       host_din_o;
  logic [ADDR_W-1:0] sram_addr_o;
  logic [15:0]       sram_dq_i;
  logic [15:0]       sram_dq_o;
  logic              sram_dq_oe_o, sram_oe_n_o, sram_we_n_o, sram_lb_n_o, sram_ub_n_o;
  arb_state_t        dbg_state;

  sram_arbiter #(.ADDR_W(ADDR_W), .VIDEO_BASE(5'b00001)) dut (
    .clk25(clk25), .reset_n(reset_n),
    .video_load_i(video_load_i), .video_addr_i(video_addr_i), .video_data_o(video_data_o),
    .cpu_rd_i(cpu_rd_i), .cpu_wt_i(cpu_wt_i), .cpu_byte_i(cpu_byte_i),
    .cpu_adr_i(cpu_adr_i), .cpu_dout_i(cpu_dout_i),
    .cpu_din_o(cpu_din_o), .cpu_reply_o(cpu_reply_o),
    .host_req_i(host_req_i), .host_we_n_i(host_we_n_i), .host_addr_i(host_addr_i),
    .host_dout_i(host_dout_i), .host_ack_o(host_ack_o), .host_din_o(host_din_o),
    .sram_addr_o(sram_addr_o), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
    .sram_dq_oe_o(sram_dq_oe_o), .sram_oe_n_o(sram_oe_n_o), .sram_we_n_o(sram_we_n_o),
    .sram_lb_n_o(sram_lb_n_o), .sram_ub_n_o(sram_ub_n_o),
    .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  int dev_gen  = 0;
  bit vid_en    = 1'b0;
  bit vid_force = 1'b0;

  logic [15:0] dev_mem [int unsigned];
  logic [15:0] ref_mem [int unsigned];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] fill(input logic [ADDR_W-1:0] a);
    logic [15:0] t;
    t = a[15:0];
    return (t * 16'h9E37) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] dev_read(input logic [ADDR_W-1:0] a);
    if (dev_mem.exists(a)) return dev_mem[a];
    return fill(a);
  endfunction

  function automatic logic [15:0] ref_read(input logic [ADDR_W-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return fill(a);
  endfunction

  // ---------------- SRAM device model ----------------
  initial forever begin
    sram_dq_i = sram_oe_n_o ? 16'h0000 : dev_read(sram_addr_o);
    @(sram_addr_o or sram_oe_n_o or dev_gen);
  end

  initial forever begin
    logic [15:0] w;
    @(negedge clk25);
    if (sram_we_n_o === 1'b0) begin
      we_cnt++;
      w = dev_read(sram_addr_o);
      if (sram_lb_n_o === 1'b0) w[7:0]  = sram_dq_o[7:0];
      if (sram_ub_n_o === 1'b0) w[15:8] = sram_dq_o[15:8];
      dev_mem[sram_addr_o] = w;
      dev_gen++;
    end
  end

  // ---------------- video slot generator / checker ----------------
  initial begin : video_proc
    int          vid_cnt;
    bit          vpend;
    logic [15:0] vexp;
    logic [ADDR_W-1:0] va;
    vid_cnt = 0;
    vpend = 1'b0;
    vexp = '0;
    forever begin
      @(posedge clk25); #1;
      if (vpend && reset_n === 1'b1) chk("video_data", video_data_o, vexp);
      vpend = 1'b0;
      vid_cnt = (vid_cnt + 1) % 16;
      video_load_i = vid_en ? (vid_cnt == 0) : vid_force;
      if (video_load_i) video_addr_i = 13'($urandom);
      #2;
      if (video_load_i && reset_n === 1'b1) begin
        va = ADDR_W'({5'b00001, video_addr_i});
        chk("video_addr", sram_addr_o, va);
        chk("video_oe_n", sram_oe_n_o, 1'b0);
        chk("video_no_write", {sram_we_n_o, sram_dq_oe_o}, 2'b10);
        vexp  = dev_read(va);
        vpend = 1'b1;
      end
    end
  end

  // ---------------- CPU transaction driver + reference ----------------
  task automatic cpu_access(input bit wr, input bit bm, input logic [15:0] adr,
                            input logic [15:0] wd, input int exp_lat, input bit vid_first);
    int cyc, acc_cyc, we0, hold;
    logic [ADDR_W-1:0] a_seen, wa;
    logic lb_seen, ub_seen;
    logic [15:0] dq_seen, w;
    acc_cyc = -1; a_seen = '0; lb_seen = 1'b1; ub_seen = 1'b1; dq_seen = '0;
    we0 = we_cnt;
    wa  = ADDR_W'(adr[15:1]);
    vid_force = vid_first;
    @(posedge clk25); #2;
    cpu_adr_i = adr; cpu_byte_i = bm; cpu_dout_i = wd;
    cpu_rd_i = ~wr; cpu_wt_i = wr;
    cyc = 0;
    while (1) begin
      #2;
      if (!video_load_i && (sram_oe_n_o === 1'b0 || sram_we_n_o === 1'b0) && acc_cyc < 0) begin
        acc_cyc = cyc;
        a_seen = sram_addr_o; lb_seen = sram_lb_n_o; ub_seen = sram_ub_n_o; dq_seen = sram_dq_o;
      end
      vid_force = 1'b0;
      @(posedge clk25); #2;
      cyc++;
      if (cpu_reply_o === 1'b1 || cyc >= 40) break;
    end
    chk("cpu_reply_rise", cpu_reply_o, 1'b1);
    if (exp_lat >= 0) chk("cpu_access_latency", acc_cyc, exp_lat);
    chk("cpu_reply_after_access", cyc, acc_cyc + 1);
    chk("cpu_sram_addr", a_seen, wa);
    chk("cpu_lanes", {lb_seen, ub_seen}, {bm & adr[0], bm & ~adr[0]});
    if (wr) begin
      chk("cpu_we_pulses", we_cnt - we0, 1);
      chk("cpu_wdata", dq_seen, wd);
      w = ref_read(wa);
      if (!bm)        w = wd;
      else if (adr[0]) w[15:8] = wd[15:8];
      else            w[7:0]  = wd[7:0];
      ref_mem[wa] = w;
    end else begin
      chk("cpu_read_no_write", we_cnt - we0, 0);
      chk("cpu_din", cpu_din_o, ref_read(wa));
    end
    hold = $urandom_range(0, 2);
    repeat (hold) begin
      @(posedge clk25); #2;
      chk("cpu_reply_hold", cpu_reply_o, 1'b1);
    end
    cpu_rd_i = 1'b0; cpu_wt_i = 1'b0;
    @(posedge clk25); #2;
    chk("cpu_reply_clear", cpu_reply_o, 1'b0);
    chk("cpu_back_idle", dbg_state, ST_IDLE);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin : main
    int we0;
    dev_mem[256] = 16'h1234;
    ref_mem[256] = 16'h1234;

    // Reset with a video slot forced: SRAM must stay quiet, outputs zero.
    #5 reset_n = 1'b0;
    vid_force = 1'b1;
    repeat (3) begin @(posedge clk25); #2; end
    #2;
    chk("rst_oe_n", sram_oe_n_o, 1'b1);
    chk("rst_we_dqoe", {sram_we_n_o, sram_dq_oe_o}, 2'b10);
    chk("rst_reply_ack", {cpu_reply_o, host_ack_o}, 2'b00);
    chk("rst_cpu_din", cpu_din_o, 16'h0);
    chk("rst_host_din", host_din_o, 16'h0);
    chk("rst_video_data", video_data_o, 16'h0);
    chk("rst_state", dbg_state, ST_IDLE);
    vid_force = 1'b0;
    @(posedge clk25); #2;
    reset_n = 1'b1;
    repeat (2) @(posedge clk25);

    // Word read of 0o1000 -> SRAM word 0o400 holding 16'h1234.
    cpu_access(1'b0, 1'b0, 16'o1000, 16'h0, 1, 1'b0);
    chk("read_0o1000_data", cpu_din_o, 16'h1234);

    // Byte write to odd 0o1001: upper lane only, then read the word back.
    cpu_access(1'b1, 1'b1, 16'o1001, 16'hAB77, 1, 1'b0);
    cpu_access(1'b0, 1'b0, 16'o1000, 16'h0, 1, 1'b0);
    chk("byte_write_merge", cpu_din_o, 16'hAB34);

    // Even byte write, full word write, and a read edge colliding with video.
    cpu_access(1'b1, 1'b1, 16'o1000, 16'h00CD, 1, 1'b0);
    cpu_access(1'b1, 1'b0, 16'o1002, 16'hBEEF, 1, 1'b0);
    cpu_access(1'b0, 1'b0, 16'o1000, 16'h0, 2, 1'b1);
    chk("even_byte_merge", cpu_din_o, 16'hABCD);

`ifdef HOST_PORT_EN
    begin : host_blk
      int cpu_seen, host_seen;
      cpu_seen = -1; host_seen = -1;
      @(posedge clk25); #2;
      host_req_i = 1'b1; host_we_n_i = 1'b1; host_addr_i = ADDR_W'(18'h00101);
      cpu_adr_i = 16'o1000; cpu_byte_i = 1'b0; cpu_rd_i = 1'b1;
      for (int c = 1; c < 40 && host_seen < 0; c++) begin
        @(posedge clk25); #2;
        if (cpu_reply_o === 1'b1 && cpu_seen < 0) cpu_seen = c;
        if (cpu_seen >= 0) cpu_rd_i = 1'b0;
        if (host_ack_o === 1'b1) begin host_seen = c; host_req_i = 1'b0; end
      end
      chk("prio_cpu_first", cpu_seen, 2);
      chk("prio_host_after", host_seen, cpu_seen + 3);
      chk("host_din", host_din_o, ref_read(ADDR_W'(18'h00101)));
      @(posedge clk25); #2;
      chk("host_ack_single", host_ack_o, 1'b0);
    end
`else
    begin : host_off_blk
      int ack_seen, acc_seen;
      ack_seen = 0; acc_seen = 0;
      @(posedge clk25); #2;
      host_req_i = 1'b1; host_we_n_i = 1'b1; host_addr_i = ADDR_W'(18'h00101);
      repeat (30) begin
        @(posedge clk25); #2;
        if (host_ack_o !== 1'b0) ack_seen++;
        if (sram_oe_n_o !== 1'b1 || sram_we_n_o !== 1'b1) acc_seen++;
      end
      chk("host_off_ack", ack_seen, 0);
      chk("host_off_access", acc_seen, 0);
      chk("host_off_din", host_din_o, 16'h0);
      host_req_i = 1'b0;
    end
`endif

    // Reset during a CPU write: access aborted, nothing written afterwards.
    we0 = we_cnt;
    @(posedge clk25); #2;
    cpu_adr_i = 16'o2000; cpu_byte_i = 1'b0; cpu_dout_i = 16'hDEAD; cpu_wt_i = 1'b1;
    @(posedge clk25); #4;
    chk("rstw_we_active", sram_we_n_o, 1'b0);
    #4 reset_n = 1'b0;
    #2;
    chk("rstw_we_released", {sram_we_n_o, sram_dq_oe_o}, 2'b10);
    @(posedge clk25); #2;
    reset_n = 1'b1;
    repeat (5) @(posedge clk25);
    #2;
    chk("rstw_no_write", we_cnt - we0, 0);
    chk("rstw_reply", cpu_reply_o, 1'b0);
    chk("rstw_state", dbg_state, ST_IDLE);
    cpu_wt_i = 1'b0;
    repeat (2) @(posedge clk25);

    // Random CPU traffic under periodic video slots.
    vid_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cpu_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 16'o1000 + 16'($urandom_range(0, 15)), 16'($urandom), -1, 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk25);
    end
    vid_en = 1'b0;
    repeat (3) @(posedge clk25);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, SRAM word-address width.
REQ-002 SHALL have parameter VIDEO_BASE, default 5'b00001, upper address bits prepended to video_addr_i.
REQ-003 SHALL have port clk25  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port video_load_i  in  1  video slot strobe, one cycle in every 16.
REQ-006 SHALL have ports video_addr_i  in  13  (video word address) and video_data_o  out  16  (fetched video word).
REQ-007 SHALL have ports cpu_rd_i, cpu_wt_i, cpu_byte_i  in  1 each; cpu_adr_i  in  16; cpu_dout_i  in  16.
REQ-008 SHALL have ports cpu_din_o  out  16  (latched read data) and cpu_reply_o  out  1  (cycle acknowledge).
REQ-009 SHALL have ports host_req_i, host_we_n_i  in  1; host_addr_i  in  ADDR_W; host_dout_i  in  16; host_ack_o  out  1; host_din_o  out  16.
REQ-010 SHALL have ports sram_addr_o  out  ADDR_W; sram_dq_i  in  16; sram_dq_o  out  16; sram_dq_oe_o  out  1; sram_oe_n_o, sram_we_n_o, sram_lb_n_o, sram_ub_n_o  out  1 each.

Function
REQ-011 SHALL register cpu_rd_i/cpu_wt_i each cycle and latch a pending CPU request on a rising edge of either.
REQ-012 SHALL run FSM states IDLE, CPU_ACC, HOST_ACC, WAIT_END.
REQ-013 In any cycle with video_load_i=1, SHALL drive sram_addr_o={VIDEO_BASE,video_addr_i}, sram_oe_n_o=0, both lane enables 0, and capture sram_dq_i into video_data_o at that edge; video has absolute priority.
REQ-014 IDLE->CPU_ACC when a CPU request is pending and video_load_i=0; IDLE->HOST_ACC when host_req_i=1, no CPU request is pending, and video_load_i=0.
REQ-015 CPU_ACC SHALL last exactly one cycle, driving sram_addr_o={0,cpu_adr_i[15:1]}; reads assert sram_oe_n_o=0; writes assert sram_we_n_o=0, sram_dq_oe_o=1, sram_dq_o=cpu_dout_i.
REQ-016 Lanes: sram_lb_n_o=cpu_byte_i&cpu_adr_i[0]; sram_ub_n_o=cpu_byte_i&~cpu_adr_i[0].
REQ-017 At the end of a CPU_ACC read, SHALL latch sram_dq_i into cpu_din_o; any CPU_ACC SHALL set cpu_reply_o=1 and enter WAIT_END.
REQ-018 In WAIT_END, cpu_reply_o SHALL hold 1 until cpu_rd_i=cpu_wt_i=0, then clear on the next edge and return to IDLE.
REQ-019 HOST_ACC SHALL last one cycle (host_addr_i, both lanes enabled), latch host_din_o on reads, and pulse host_ack_o for exactly one cycle.
REQ-020 A CPU edge arriving during HOST_ACC SHALL stay pending and be served next eligible cycle; no request is ever dropped.
REQ-021 When idle, SHALL drive sram_oe_n_o=1, sram_we_n_o=1, sram_dq_oe_o=0.
REQ-022 sram_we_n_o and sram_dq_oe_o SHALL never be active in a video slot.

Reset
REQ-023 While reset_n=0, SHALL force FSM=IDLE, pending=0, cpu_reply_o=0, host_ack_o=0, cpu_din_o=host_din_o=video_data_o=0, and SRAM controls inactive.
REQ-024 Reset asserted mid-access SHALL abort the access with no write completed after deassertion.

Configuration
REQ-025 With HOST_PORT_EN defined, the host path operates as above; without it, HOST_ACC is unreachable, host_ack_o=0, and host_din_o=0.

Structure
REQ-026 FSM state encoding and VIDEO_BASE default SHALL live in shared package bk_mem_pkg.
REQ-027 Rising-edge request detection SHALL be sub-module req_edge_det.

Verification
REQ-028 CPU read of adr 0o1000, SRAM returns 16'h1234 -> sram_addr_o=0o400, cpu_din_o=16'h1234, cpu_reply_o high until rd drops.
REQ-029 CPU byte write to odd adr 0o1001 -> sram_lb_n_o=1, sram_ub_n_o=0, sram_we_n_o low for one cycle.
REQ-030 CPU rd edge coincident with video_load_i -> video serviced first, CPU_ACC one cycle later.
REQ-031 host_req_i and CPU edge in same cycle -> CPU served first, host_ack_o pulses afterwards.
REQ-032 reset_n low during CPU_ACC write -> no we_n pulse after release; cpu_reply_o=0.
REQ-033 HOST_PORT_EN undefined, host_req_i=1 held -> host_ack_o never asserts.
